video_regfile_avmm: RTL and testbench
=====================================

# video_regfile_avmm

Parametrised Avalon-MM slave register file for the video IP, the successor to the fixed 8×32 control-register slave. It supports configurable width and depth, byte enables, and per-register read-only hardware inputs. It also adds a write-1-to-clear status register with a level interrupt, and per-register write strobes. It sits between the Avalon interconnect and the video datapath, which consumes `regs_out` and feeds `hw_in` and `status_set`.

## Interface
- `DATA_W`, 32, register and bus width; must be a multiple of 8.
- `NUM_REGS`, 8, number of registers; valid range 2..2^`ADDR_W`.
- `ADDR_W`, 3, word address width.
- `RO_MASK`, 0 (`NUM_REGS` bits), bit i = 1: register i is read-only from the bus and reads `hw_in` slice i.
- `STATUS_ADDR`, 6, index of the W1C status register.
- `IRQEN_ADDR`, 7, index of the interrupt-enable register (normal R/W).
- `clk` in 1 — single clock; all logic rising-edge.
- `reset_n` in 1 — asynchronous, active-low reset.
- `chipselect` in 1 — slave selected.
- `address` in `ADDR_W` — word address.
- `write` in 1 — write request.
- `writedata` in `DATA_W` — write data.
- `byteenable` in `DATA_W/8` — per-byte write enable.
- `read` in 1 — read request.
- `readdata` out `DATA_W` — read data.
- `readdatavalid` out 1 — `readdata` valid this cycle.
- `regs_out` out `NUM_REGS*DATA_W` — all register contents; register i occupies bits [i*DATA_W +: DATA_W].
- `hw_in` in `NUM_REGS*DATA_W` — hardware values for `RO_MASK` registers; same slicing as `regs_out`.
- `status_set` in `DATA_W` — per-bit event pulses that set status bits.
- `wr_strobe` out `NUM_REGS` — one-cycle pulse per bus-written register.
- `irq` out 1 — level interrupt.

## Operation
- **Write acceptance.** A write is accepted in cycle N when `chipselect && write`.
- **R/W registers.** For a R/W register (not RO, not `STATUS_ADDR`), each byte with `byteenable` set takes the corresponding `writedata` byte; other bytes keep their value.
- **Ignored writes.** Writes to RO registers, or to `address >= NUM_REGS`, change nothing and raise no strobe.
- **Status register (W1C).**
  - Bus write at `STATUS_ADDR`: each enabled byte clears the bits where `writedata` is 1.
  - Every cycle: `status_next = (status & ~clr_mask) | status_set`.
  - Set wins over clear on the same bit in the same cycle.
  - `status_set` is honoured every cycle, independent of the bus.
- **Write strobes.** `wr_strobe[i]` is registered and pulses in cycle N+1 for an accepted write to register i that has at least one `byteenable` bit set. This includes `STATUS_ADDR` and `IRQEN_ADDR`.
- **Read acceptance.** A read is accepted in cycle N when `chipselect && read`. It returns, sampled in cycle N:
  - R/W register or status: the stored value.
  - RO register: its `hw_in` slice.
  - `address >= NUM_REGS`: 0.
- **Simultaneous read and write.** If read and write target the same address in the same cycle, the read returns the pre-write value.
- **Interrupt.** `irq` is registered: `irq <= |(status & irqen)`, computed from the current register contents. It stays high until all enabled status bits are cleared or disabled.
- **`regs_out`.** Reflects stored values; RO slices are driven as 0.
- **Outputs inactive when `chipselect` is low.** No reads or writes are accepted, so no strobes and no `readdatavalid`.

## Timing
- **Reset.** Asserting `reset_n` low immediately clears:
  - all registers, `status`, `irqen`;
  - `readdata` = 0, `readdatavalid` = 0, `wr_strobe` = 0, `irq` = 0.
- **Reset mid-operation.** A read accepted in the cycle before reset produces no `readdatavalid`. A write accepted in that cycle is lost.
- **Read latency.** Exactly 1 cycle: `readdatavalid` is high in N+1 for one cycle per accepted read.
  - Back-to-back reads every cycle give continuous `readdatavalid`.
  - `readdata` holds its last value when `readdatavalid` is low.
- **No stalls.** There is no `waitrequest`; every request is accepted in the cycle presented.
- **Write visibility.** `regs_out` reflects a write from cycle N+1. A read accepted in N+1 returns the new value.
- **Status-to-interrupt latency.**
  - `status_set` pulse in cycle N: status bit set in N+1, `irq` high in N+2 if enabled.
  - W1C in N: bit clears in N+1, `irq` drops in N+2.

## Test plan
- **Reset, read, and address decode.** After reset, write 0xDEADBEEF to reg 0, then read reg 0 → `readdatavalid` one cycle later with 0xDEADBEEF, and `wr_strobe[0]` pulses once. Read address 8 with `NUM_REGS`=8, `ADDR_W`=4 → `readdata` = 0 with `readdatavalid` high.
- **Byte enables.** Reg 1 = 0x11223344; write 0xAABBCCDD with `byteenable` = 4'b0101 → reg 1 = 0x11BB33DD. Write with `byteenable` = 0 → no change and no strobe.
- **Read-only register.** `RO_MASK` bit 2 set, `hw_in` slice 2 = 0x00C0FFEE. Write 0xFFFFFFFF to reg 2 → no strobe; read of reg 2 returns 0x00C0FFEE.
- **Status and interrupt.** `irqen` = 0x1; pulse `status_set` = 0x3 → status = 0x3 and `irq` high two cycles later. Write 0x1 to `STATUS_ADDR` → status = 0x2 and `irq` low two cycles after the write. Repeat with `status_set` bit 0 asserted in the same cycle as the W1C → bit 0 stays set.
- **Read/write collision and throughput.** Reg 3 = 5; write 9 to reg 3 and read reg 3 in the same cycle → read returns 5, and the next read returns 9. Issue four consecutive reads → four consecutive `readdatavalid` cycles.
- **Asynchronous reset.** Drop `reset_n` between clock edges right after a read is accepted → all outputs are 0 immediately and no `readdatavalid` follows.

Source files
------------

// File: rtl/video_regfile_avmm_if.sv
// Avalon-MM slave bus bundle for the video register file.
interface video_regfile_avmm_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3
);
    logic                  chipselect;
    logic [ADDR_W-1:0]     address;
    logic                  write;
    logic [DATA_W-1:0]     writedata;
    logic [DATA_W/8-1:0]   byteenable;
    logic                  read;
    logic [DATA_W-1:0]     readdata;
    logic                  readdatavalid;

    modport master (
        output chipselect, address, write, writedata, byteenable, read,
        input  readdata, readdatavalid
    );

    modport slave (
        input  chipselect, address, write, writedata, byteenable, read,
        output readdata, readdatavalid
    );
endinterface

// File: rtl/video_regfile_avmm.sv
// Parametrised Avalon-MM register file: byte-enabled R/W registers, hardware read-only
// registers, a write-1-to-clear status register with level interrupt, and per-register write strobes.
module video_regfile_avmm #(
    parameter int                  DATA_W      = 32,
    parameter int                  NUM_REGS    = 8,
    parameter int                  ADDR_W      = 3,
    parameter logic [NUM_REGS-1:0] RO_MASK     = '0,
    parameter int                  STATUS_ADDR = 6,
    parameter int                  IRQEN_ADDR  = 7
) (
    input  logic                         clk,
    input  logic                         reset_n,
    video_regfile_avmm_if.slave          bus,
    output logic [NUM_REGS*DATA_W-1:0]   regs_out,
    input  logic [NUM_REGS*DATA_W-1:0]   hw_in,
    input  logic [DATA_W-1:0]            status_set,
    output logic [NUM_REGS-1:0]          wr_strobe,
    output logic                         irq
);
    localparam int NBYTES = DATA_W / 8;

    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic [DATA_W-1:0]   w_regs_next [NUM_REGS];
    logic [DATA_W-1:0]   w_be_mask;
    logic [DATA_W-1:0]   w_rdata;
    logic [NUM_REGS-1:0] w_strobe_next;
    logic                w_wr;
    logic                w_rd;
    logic [DATA_W-1:0]   r_readdata;
    logic                r_readdatavalid;
    logic [NUM_REGS-1:0] r_wr_strobe;
    logic                r_irq;

    assign w_wr = bus.chipselect && bus.write;
    assign w_rd = bus.chipselect && bus.read;

    always_comb begin
        w_be_mask = '0;
        for (int b = 0; b < NBYTES; b++) begin
            w_be_mask[b*8 +: 8] = {8{bus.byteenable[b]}};
        end
    end

    // Out-of-range addresses match no index, so they write nothing and read zero.
    always_comb begin
        w_strobe_next = '0;
        w_rdata       = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_regs_next[i] = r_regs[i];
            if (RO_MASK[i]) begin
                w_regs_next[i] = '0;
            end else if (i == STATUS_ADDR) begin
                if (w_wr && (int'(bus.address) == i)) begin
                    w_regs_next[i] = (r_regs[i] & ~(bus.writedata & w_be_mask)) | status_set;
                end else begin
                    w_regs_next[i] = r_regs[i] | status_set;
                end
            end else if (w_wr && (int'(bus.address) == i)) begin
                w_regs_next[i] = (r_regs[i] & ~w_be_mask) | (bus.writedata & w_be_mask);
            end
            w_strobe_next[i] = w_wr && (int'(bus.address) == i) && (|bus.byteenable) && !RO_MASK[i];
            if (int'(bus.address) == i) begin
                w_rdata = RO_MASK[i] ? hw_in[i*DATA_W +: DATA_W] : r_regs[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_readdata      <= '0;
            r_readdatavalid <= 1'b0;
            r_wr_strobe     <= '0;
            r_irq           <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= w_regs_next[i];
            end
            r_readdatavalid <= w_rd;
            if (w_rd) begin
                r_readdata <= w_rdata;
            end
            r_wr_strobe <= w_strobe_next;
            r_irq       <= |(r_regs[STATUS_ADDR] & r_regs[IRQEN_ADDR]);
        end
    end

    always_comb begin
        regs_out = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_out[i*DATA_W +: DATA_W] = RO_MASK[i] ? '0 : r_regs[i];
        end
    end

    assign bus.readdata      = r_readdata;
    assign bus.readdatavalid = r_readdatavalid;
    assign wr_strobe         = r_wr_strobe;
    assign irq               = r_irq;
endmodule

// File: tb/tb_video_regfile_avmm.sv
// Directed self-checking bench for video_regfile_avmm (8 regs, 4-bit address, reg 2 read-only).
module tb_video_regfile_avmm;
    localparam int DW = 32;
    localparam int NR = 8;
    localparam int AW = 4;

    logic            clk;
    logic            reset_n;
    logic [NR*DW-1:0] regsOut;
    logic [NR*DW-1:0] hwIn;
    logic [DW-1:0]   statusSet;
    logic [NR-1:0]   wrStrobe;
    logic            irq;
    int              checks;
    int              errors;

    video_regfile_avmm_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    video_regfile_avmm #(
        .DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .RO_MASK(8'b0000_0100),
        .STATUS_ADDR(6), .IRQEN_ADDR(7)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus), .regs_out(regsOut), .hw_in(hwIn),
        .status_set(statusSet), .wr_strobe(wrStrobe), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents one bus cycle, then returns 1 ns after the capturing edge.
    task automatic applyStimulus(input logic cs, input logic wr, input logic rd,
                                 input logic [AW-1:0] addr, input logic [DW-1:0] data,
                                 input logic [3:0] be);
        bus.chipselect = cs;
        bus.write      = wr;
        bus.read       = rd;
        bus.address    = addr;
        bus.writedata  = data;
        bus.byteenable = be;
        @(posedge clk);
        #1;
        bus.chipselect = 1'b0;
        bus.write      = 1'b0;
        bus.read       = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                               input logic [DW-1:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset_n = 1'b0;
        statusSet = '0;
        hwIn = '0;
        hwIn[2*DW +: DW] = 32'h00C0FFEE;
        bus.chipselect = 1'b0;
        bus.write = 1'b0;
        bus.read = 1'b0;
        bus.address = '0;
        bus.writedata = '0;
        bus.byteenable = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_readdata", bus.readdata, 32'h0);
        checkOutput("rst_rdv", {31'b0, bus.readdatavalid}, 32'h0);
        checkOutput("rst_strobe", {24'b0, wrStrobe}, 32'h0);
        checkOutput("rst_irq", {31'b0, irq}, 32'h0);
        checkOutput("rst_regs_lo", regsOut[DW-1:0], 32'h0);
        reset_n = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0);

        // Write and read back reg 0
        applyStimulus(1, 1, 0, 0, 32'hDEADBEEF, 4'hF);
        checkOutput("wr0_strobe", {24'b0, wrStrobe}, 32'h01);
        checkOutput("wr0_regs", regsOut[0 +: DW], 32'hDEADBEEF);
        applyStimulus(1, 0, 1, 0, 0, 0);
        checkOutput("rd0_rdv", {31'b0, bus.readdatavalid}, 32'h1);
        checkOutput("rd0_data", bus.readdata, 32'hDEADBEEF);
        checkOutput("wr0_strobe_once", {24'b0, wrStrobe}, 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("idle_rdv", {31'b0, bus.readdatavalid}, 32'h0);
        checkOutput("idle_hold", bus.readdata, 32'hDEADBEEF);

        // Out-of-range read and write
        applyStimulus(1, 0, 1, 4'd8, 0, 0);
        checkOutput("rd8_rdv", {31'b0, bus.readdatavalid}, 32'h1);
        checkOutput("rd8_data", bus.readdata, 32'h0);
        applyStimulus(1, 1, 0, 4'd9, 32'h12345678, 4'hF);
        checkOutput("wr9_strobe", {24'b0, wrStrobe}, 32'h0);

        // Byte enables
        applyStimulus(1, 1, 0, 1, 32'h11223344, 4'hF);
        applyStimulus(1, 1, 0, 1, 32'hAABBCCDD, 4'b0101);
        checkOutput("be_strobe", {24'b0, wrStrobe}, 32'h02);
        checkOutput("be_regs1", regsOut[1*DW +: DW], 32'h11BB33DD);
        applyStimulus(1, 1, 0, 1, 32'hFFFFFFFF, 4'b0000);
        checkOutput("be0_strobe", {24'b0, wrStrobe}, 32'h0);
        checkOutput("be0_regs1", regsOut[1*DW +: DW], 32'h11BB33DD);

        // Read-only register
        applyStimulus(1, 1, 0, 2, 32'hFFFFFFFF, 4'hF);
        checkOutput("ro_strobe", {24'b0, wrStrobe}, 32'h0);
        checkOutput("ro_regs2", regsOut[2*DW +: DW], 32'h0);
        applyStimulus(1, 0, 1, 2, 0, 0);
        checkOutput("ro_read", bus.readdata, 32'h00C0FFEE);

        // Status and interrupt
        applyStimulus(1, 1, 0, 7, 32'h1, 4'hF);
        checkOutput("irqen_strobe", {24'b0, wrStrobe}, 32'h80);
        statusSet = 32'h3;
        applyStimulus(0, 0, 0, 0, 0, 0);
        statusSet = 32'h0;
        checkOutput("set_status", regsOut[6*DW +: DW], 32'h3);
        checkOutput("set_irq_n1", {31'b0, irq}, 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("set_irq_n2", {31'b0, irq}, 32'h1);
        applyStimulus(1, 1, 0, 6, 32'h1, 4'hF);
        checkOutput("w1c_status", regsOut[6*DW +: DW], 32'h2);
        checkOutput("w1c_strobe", {24'b0, wrStrobe}, 32'h40);
        checkOutput("w1c_irq_n1", {31'b0, irq}, 32'h1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("w1c_irq_n2", {31'b0, irq}, 32'h0);
        applyStimulus(1, 0, 1, 6, 0, 0);
        checkOutput("status_read", bus.readdata, 32'h2);
        statusSet = 32'h1;
        applyStimulus(0, 0, 0, 0, 0, 0);
        statusSet = 32'h0;
        checkOutput("reset_status", regsOut[6*DW +: DW], 32'h3);
        statusSet = 32'h1;
        applyStimulus(1, 1, 0, 6, 32'h1, 4'hF);
        statusSet = 32'h0;
        checkOutput("set_wins", regsOut[6*DW +: DW], 32'h3);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("set_wins_irq", {31'b0, irq}, 32'h1);

        // Read/write collision
        applyStimulus(1, 1, 0, 3, 32'd5, 4'hF);
        applyStimulus(1, 1, 1, 3, 32'd9, 4'hF);
        checkOutput("coll_old", bus.readdata, 32'd5);
        checkOutput("coll_regs3", regsOut[3*DW +: DW], 32'd9);
        applyStimulus(1, 0, 1, 3, 0, 0);
        checkOutput("coll_new", bus.readdata, 32'd9);

        // Back-to-back reads
        applyStimulus(1, 0, 1, 0, 0, 0);
        checkOutput("b2b0_rdv", {31'b0, bus.readdatavalid}, 32'h1);
        checkOutput("b2b0_data", bus.readdata, 32'hDEADBEEF);
        applyStimulus(1, 0, 1, 1, 0, 0);
        checkOutput("b2b1_rdv", {31'b0, bus.readdatavalid}, 32'h1);
        checkOutput("b2b1_data", bus.readdata, 32'h11BB33DD);
        applyStimulus(1, 0, 1, 3, 0, 0);
        checkOutput("b2b2_rdv", {31'b0, bus.readdatavalid}, 32'h1);
        checkOutput("b2b2_data", bus.readdata, 32'd9);
        applyStimulus(1, 0, 1, 8, 0, 0);
        checkOutput("b2b3_rdv", {31'b0, bus.readdatavalid}, 32'h1);
        checkOutput("b2b3_data", bus.readdata, 32'h0);
        applyStimulus(0, 0, 1, 0, 0, 0);
        checkOutput("cs_low_rdv", {31'b0, bus.readdatavalid}, 32'h0);

        // Asynchronous reset right after an accepted read
        applyStimulus(1, 0, 1, 0, 0, 0);
        checkOutput("pre_rst_rdv", {31'b0, bus.readdatavalid}, 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("arst_rdv", {31'b0, bus.readdatavalid}, 32'h0);
        checkOutput("arst_data", bus.readdata, 32'h0);
        checkOutput("arst_irq", {31'b0, irq}, 32'h0);
        checkOutput("arst_regs0", regsOut[0 +: DW], 32'h0);
        checkOutput("arst_status", regsOut[6*DW +: DW], 32'h0);
        @(posedge clk);
        #1;
        checkOutput("arst_no_rdv", {31'b0, bus.readdatavalid}, 32'h0);
        reset_n = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
